transmitter: RTL and testbench
==============================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 SHALL: parameter CLOCKS_PER_PULSE, default 16, clk cycles per serial bit (>=2).
REQ-002 SHALL: parameter PARITY_EN, default 0, 1 = append parity bit after data.
REQ-003 SHALL: parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0).
REQ-004 SHALL: parameter STOP_BITS, default 1, number of stop bits (legal values 1 or 2).
REQ-005 SHALL: clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL: rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL: data_in  input  8  byte to transmit, sampled when data_valid and data_ready are both high.
REQ-008 SHALL: data_valid  input  1  upstream byte offer.
REQ-009 SHALL: data_ready  output  1  holding register empty; byte accepted on any edge where data_valid=1 and data_ready=1.
REQ-010 SHALL: tx  output  1  serial line, registered, idle high.
REQ-011 SHALL: busy  output  1  high while a frame is in progress or the holding register is full.

Function
REQ-012 SHALL: frame = 1 start bit (0), 8 data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
REQ-013 SHALL: every bit holds tx constant for exactly CLOCKS_PER_PULSE cycles; the per-bit counter width is $clog2(CLOCKS_PER_PULSE).
REQ-014 SHALL: states TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP; transitions occur only on counter terminal count (CLOCKS_PER_PULSE-1), except leaving TX_IDLE.
REQ-015 SHALL: TX_IDLE -> TX_START on the first edge at which the holding register is full; the byte moves into the shift register and the holding register empties on that edge.
REQ-016 SHALL: latency: byte accepted at edge N with engine idle -> tx low from edge N+1.
REQ-017 SHALL: TX_DATA -> TX_PARITY after bit 7 when PARITY_EN=1, else -> TX_STOP.
REQ-018 SHALL: parity bit = XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-019 SHALL: TX_STOP lasts STOP_BITS*CLOCKS_PER_PULSE cycles; at its end -> TX_START directly if holding register full (no idle gap), else -> TX_IDLE.
REQ-020 SHALL: data_ready = not holding-full (registered flag); a byte SHALL NOT be accepted on the same edge the engine drains the holding register.
REQ-021 SHALL: data_in changes while data_ready=0 have no effect; an in-flight frame is never altered by new input.
REQ-022 SHALL: busy = (state != TX_IDLE) or holding-full.

Reset
REQ-023 SHALL: while rstn=0 at an edge: tx=1, data_ready=1, busy=0, state=TX_IDLE, counters=0, holding register empty.
REQ-024 SHALL: reset mid-frame aborts the frame; tx returns high on that edge, any held byte is discarded, no partial frame resumes afterwards.

Structure
REQ-025 SHALL: shared package uart_pkg holds the tx state enum typedef and the start/stop bit level constants, also usable by the receiver.
REQ-026 SHALL: single module, no sub-module; holding register and shift engine live in one always_ff block plus combinational assigns.

Verification
REQ-027 SHALL: 8N1, CPP=16, send 0xA5 at edge 0 -> tx low edges 1-16, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, stop high 16, busy low at edge 161.
REQ-028 SHALL: 0x55 then 0x0F offered continuously -> second accepted while first shifts, frames contiguous (320 cycles), data_ready low while holding full, third offer stalled.
REQ-029 SHALL: PARITY_EN=1: 0x07 even -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame 176 cycles.
REQ-030 SHALL: STOP_BITS=2, send 0x00 -> stop interval 32 cycles high, frame 176 cycles, then busy=0.
REQ-031 SHALL: rstn=0 at cycle 50 of 0x00 frame with byte held -> tx=1, busy=0, data_ready=1 next edge; no further start bit without new input.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and line-level constants
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam logic START_BIT_LEVEL = 1'b0;
    localparam logic STOP_BIT_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL      = 1'b1;

    // Parity over one byte; odd=1 inverts the even-parity result
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/transmitter.sv
// rtl/transmitter.sv - UART transmitter with one-byte holding register
module transmitter
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int PARITY_EN        = 0,
    parameter int PARITY_ODD       = 0,
    parameter int STOP_BITS        = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CNT_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       hold;
    logic             hold_full;
    logic [7:0]       shift;
    logic             par_bit;

    // Holding register accept plus the bit-serial shift engine; tx is registered
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= TX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            par_bit   <= 1'b0;
            tx        <= IDLE_LEVEL;
        end else begin
            // Accept only while empty; the drain below only fires while full,
            // so accept and drain can never coincide on one edge.
            if (data_valid && !hold_full) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end

            case (state)
                TX_IDLE: begin
                    if (hold_full) begin
                        state     <= TX_START;
                        shift     <= hold;
                        par_bit   <= calc_parity(hold, ODD);
                        hold_full <= 1'b0;
                        cnt       <= '0;
                        tx        <= START_BIT_LEVEL;
                    end
                end
                default: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        case (state)
                            TX_START: begin
                                state   <= TX_DATA;
                                bit_idx <= '0;
                                tx      <= shift[0];
                            end
                            TX_DATA: begin
                                if (bit_idx == 3'd7) begin
                                    bit_idx <= '0;
                                    if (PARITY_EN != 0) begin
                                        state <= TX_PARITY;
                                        tx    <= par_bit;
                                    end else begin
                                        state <= TX_STOP;
                                        tx    <= STOP_BIT_LEVEL;
                                    end
                                end else begin
                                    bit_idx <= bit_idx + 3'd1;
                                    shift   <= {1'b0, shift[7:1]};
                                    tx      <= shift[1];
                                end
                            end
                            TX_PARITY: begin
                                state   <= TX_STOP;
                                bit_idx <= '0;
                                tx      <= STOP_BIT_LEVEL;
                            end
                            TX_STOP: begin
                                if (bit_idx != STOP_LAST) begin
                                    bit_idx <= bit_idx + 3'd1;
                                end else if (hold_full) begin
                                    // Back-to-back frame with no idle gap
                                    state     <= TX_START;
                                    bit_idx   <= '0;
                                    shift     <= hold;
                                    par_bit   <= calc_parity(hold, ODD);
                                    hold_full <= 1'b0;
                                    tx        <= START_BIT_LEVEL;
                                end else begin
                                    state   <= TX_IDLE;
                                    bit_idx <= '0;
                                    tx      <= IDLE_LEVEL;
                                end
                            end
                            default: begin
                                state <= TX_IDLE;
                                tx    <= IDLE_LEVEL;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign data_ready = !hold_full;
    assign busy       = (state != TX_IDLE) || hold_full;

endmodule

// File: tb/tb_transmitter.sv
// tb/tb_transmitter.sv - directed table-driven bench for transmitter
module tb_transmitter;

    logic       clk;
    logic       rstn;
    logic [7:0] din    [4];
    logic       dv     [4];
    logic       tx_o   [4];
    logic       rdy_o  [4];
    logic       busy_o [4];

    int checks;
    int failures;

    // dut 0: 8N1, dut 1: 8E1, dut 2: 8O1, dut 3: 8N2
    transmitter #(.CLOCKS_PER_PULSE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .data_in(din[0]), .data_valid(dv[0]),
        .data_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]));
    transmitter #(.CLOCKS_PER_PULSE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .data_in(din[1]), .data_valid(dv[1]),
        .data_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]));
    transmitter #(.CLOCKS_PER_PULSE(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rstn(rstn), .data_in(din[2]), .data_valid(dv[2]),
        .data_ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2]));
    transmitter #(.CLOCKS_PER_PULSE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rstn(rstn), .data_in(din[3]), .data_valid(dv[3]),
        .data_ready(rdy_o[3]), .tx(tx_o[3]), .busy(busy_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        logic [7:0] data;
        logic [11:0] bits;   // frame bits, bit 0 transmitted first
        int         nbits;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_and_check(input int d, input logic [7:0] b,
                                  input logic [11:0] exp_bits, input int nbits);
        logic [11:0] cap;
        int          wobble;
        int          busy_drop;
        cap       = '0;
        wobble    = 0;
        busy_drop = 0;
        @(negedge clk);
        din[d] = b;
        dv[d]  = 1'b1;
        @(posedge clk);          // edge 0: accepted
        @(negedge clk);
        dv[d]  = 1'b0;
        for (int k = 1; k <= nbits * 16; k++) begin
            @(posedge clk);
            #1;
            if (((k - 1) % 16) == 0) cap[(k - 1) / 16] = tx_o[d];
            else if (tx_o[d] != cap[(k - 1) / 16]) wobble++;
            if (!busy_o[d]) busy_drop++;
        end
        check($sformatf("frame_bits d%0d 0x%02h", d, b), int'(cap), int'(exp_bits));
        check($sformatf("bit_stable d%0d 0x%02h", d, b), wobble + busy_drop, 0);
        @(posedge clk);
        #1;
        check($sformatf("end_idle d%0d 0x%02h", d, b),
              {29'd0, busy_o[d], tx_o[d], rdy_o[d]}, 32'b011);
        repeat (5) @(posedge clk);
    endtask

    initial begin
        logic [19:0] b2b_exp;
        int          b2b_err;
        int          stall_err;
        int          post_err;

        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din[i] = 8'h00;
            dv[i]  = 1'b0;
        end

        vecs[0] = '{0, 8'hA5, 12'b00_1_10100101_0, 10};
        vecs[1] = '{0, 8'h00, 12'b00_1_00000000_0, 10};
        vecs[2] = '{0, 8'hFF, 12'b00_1_11111111_0, 10};
        vecs[3] = '{1, 8'h07, 12'b0_1_1_00000111_0, 11};
        vecs[4] = '{1, 8'h00, 12'b0_1_0_00000000_0, 11};
        vecs[5] = '{2, 8'h07, 12'b0_1_0_00000111_0, 11};
        vecs[6] = '{2, 8'h00, 12'b0_1_1_00000000_0, 11};
        vecs[7] = '{3, 8'h00, 12'b0_11_00000000_0, 11};
        vecs[8] = '{3, 8'h81, 12'b0_11_10000001_0, 11};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            check($sformatf("reset_state d%0d", i),
                  {29'd0, busy_o[i], tx_o[i], rdy_o[i]}, 32'b011);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 9; v++)
            send_and_check(vecs[v].d, vecs[v].data, vecs[v].bits, vecs[v].nbits);

        // Back-to-back: 0x55 then 0x0F, third offer 0x33 must stall
        b2b_exp   = {10'b1_00001111_0, 10'b1_01010101_0};
        b2b_err   = 0;
        stall_err = 0;
        @(negedge clk);
        din[0] = 8'h55;
        dv[0]  = 1'b1;
        @(posedge clk);          // edge 0
        #1;
        check("b2b_ready_low_after_accept", int'(rdy_o[0]), 0);
        @(negedge clk);
        din[0] = 8'h0F;
        for (int k = 1; k <= 320; k++) begin
            @(posedge clk);
            #1;
            if (tx_o[0] != b2b_exp[(k - 1) / 16]) b2b_err++;
            if (k >= 2 && k <= 150 && rdy_o[0]) stall_err++;
            @(negedge clk);
            if (k == 2) din[0] = 8'h33;
            if (k == 150) dv[0] = 1'b0;
        end
        check("b2b_waveform", b2b_err, 0);
        check("b2b_stall_ready", stall_err, 0);
        @(posedge clk);
        #1;
        check("b2b_end_idle", {29'd0, busy_o[0], tx_o[0], rdy_o[0]}, 32'b011);
        repeat (5) @(posedge clk);

        // Reset mid-frame with a byte held
        @(negedge clk);
        din[0] = 8'h00;
        dv[0]  = 1'b1;
        @(posedge clk);          // edge 0
        @(negedge clk);
        din[0] = 8'h3C;
        @(posedge clk);          // edge 1: drain
        @(posedge clk);          // edge 2: 0x3C held
        @(negedge clk);
        dv[0] = 1'b0;
        #1;
        check("rst_held_busy", {30'd0, busy_o[0], rdy_o[0]}, 32'b10);
        for (int k = 3; k < 50; k++) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);          // edge 50
        #1;
        check("rst_mid_frame", {29'd0, busy_o[0], tx_o[0], rdy_o[0]}, 32'b011);
        @(negedge clk);
        rstn = 1'b1;
        post_err = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (!tx_o[0] || busy_o[0] || !rdy_o[0]) post_err++;
        end
        check("rst_no_resume", post_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
